gate_equiv_sweeper: RTL and testbench

Sequential equivalence checker for small combinational implementations. It drives the same stimulus vector into two implementations of one Boolean function, for example a NAND-only gate netlist and its behavioural expression. It walks every input combination in ascending order, waits a programmable settle time, compares the two results, and reports the mismatch count, the first failing vector, and pass/fail. It sits above a pair of datapath instances and is their only stimulus source and result sampler during a sweep.

---
 rtl/gate_equiv_sweeper.sv | 151 +++++++++++++++
 tb/tb_gate_equiv_sweeper.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_equiv_sweeper.sv
// gate_equiv_sweeper: walks every input vector into two implementations
// of one Boolean function and tallies where their outputs disagree.
module gate_equiv_sweeper #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            res_a,
  input  logic            res_b,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_bad,
  output logic            first_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0]      CNT_LD  = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_ONE = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE = (N_IN + 1)'(1);

  state_t state;
  state_t state_nxt;

  logic [3:0]      cnt;
  logic [3:0]      cnt_nxt;
  logic [N_IN-1:0] vec_nxt;
  logic [N_IN-1:0] first_bad_nxt;
  logic [N_IN:0]   err_nxt;
  logic            busy_nxt;
  logic            done_nxt;
  logic            pass_nxt;
  logic            fv_nxt;

  logic go;
  logic stop;
  logic set_run;
  logic chk_run;
  logic miss;
  logic last;

  // abort outranks start and the normal sweep, so the four
  // decode terms below are mutually exclusive
  assign go      = (state == S_IDLE || state == S_DONE)
                 && start && !abort;
  assign stop    = (state == S_SETTLE || state == S_CHECK)
                 && abort;
  assign set_run = (state == S_SETTLE) && !abort;
  assign chk_run = (state == S_CHECK) && !abort;
  assign miss    = res_a ^ res_b;
  assign last    = &vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      go:      state_nxt = S_SETTLE;
      stop:    state_nxt = S_IDLE;
      set_run: if (cnt == '0) state_nxt = S_CHECK;
      chk_run: state_nxt = last ? S_DONE : S_SETTLE;
      default: ;
    endcase
  end

  always_comb begin
    vec_nxt       = vec;
    cnt_nxt       = cnt;
    err_nxt       = err_cnt;
    first_bad_nxt = first_bad;
    fv_nxt        = first_valid;
    busy_nxt      = busy;
    done_nxt      = done;
    pass_nxt      = pass;
    unique case (1'b1)
      go: begin
        vec_nxt       = '0;
        err_nxt       = '0;
        first_bad_nxt = '0;
        fv_nxt        = 1'b0;
        pass_nxt      = 1'b0;
        done_nxt      = 1'b0;
        busy_nxt      = 1'b1;
        cnt_nxt       = CNT_LD;
      end
      stop: begin
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        pass_nxt = 1'b0;
      end
      set_run: begin
        if (cnt != '0) cnt_nxt = cnt - 4'd1;
      end
      chk_run: begin
        if (miss) begin
          err_nxt = err_cnt + ERR_ONE;
          if (!first_valid) begin
            first_bad_nxt = vec;
            fv_nxt        = 1'b1;
          end
        end
        if (last) begin
          busy_nxt = 1'b0;
          done_nxt = 1'b1;
          pass_nxt = (err_nxt == '0);
        end else begin
          vec_nxt = vec + VEC_ONE;
          cnt_nxt = CNT_LD;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec         <= '0;
      cnt         <= '0;
      err_cnt     <= '0;
      first_bad   <= '0;
      first_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      vec         <= vec_nxt;
      cnt         <= cnt_nxt;
      err_cnt     <= err_nxt;
      first_bad   <= first_bad_nxt;
      first_valid <= fv_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      pass        <= pass_nxt;
    end
  end

endmodule

// File: tb/tb_gate_equiv_sweeper.sv
// tb_gate_equiv_sweeper: truth-table driven sweeps of two configurations
// (N_IN=2/SETTLE=1 and N_IN=3/SETTLE=3) against a table-level model.
module tb_gate_equiv_sweeper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start2 = 1'b0;
  logic       abort2 = 1'b0;
  logic [3:0] fa2 = '0;
  logic [3:0] fb2 = '0;
  logic       ra2, rb2;
  logic [1:0] vec2;
  logic       busy2, done2, pass2, fv2;
  logic [2:0] err2;
  logic [1:0] bad2;

  logic       start3 = 1'b0;
  logic       abort3 = 1'b0;
  logic [7:0] fa3 = '0;
  logic [7:0] fb3 = '0;
  logic       ra3, rb3;
  logic [2:0] vec3;
  logic       busy3, done3, pass3, fv3;
  logic [3:0] err3;
  logic [2:0] bad3;

  assign ra2 = fa2[vec2];
  assign rb2 = fb2[vec2];
  assign ra3 = fa3[vec3];
  assign rb3 = fb3[vec3];

  gate_equiv_sweeper #(.N_IN(2), .SETTLE(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .res_a(ra2), .res_b(rb2), .vec(vec2), .busy(busy2),
    .done(done2), .pass(pass2), .err_cnt(err2),
    .first_bad(bad2), .first_valid(fv2)
  );

  gate_equiv_sweeper #(.N_IN(3), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
    .res_a(ra3), .res_b(rb3), .vec(vec3), .busy(busy3),
    .done(done3), .pass(pass3), .err_cnt(err3),
    .first_bad(bad3), .first_valid(fv3)
  );

  int passed = 0;
  int total = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    else
      passed++;
  endtask

  function automatic int g_vec(input int sel);
    return sel != 0 ? int'(vec3) : int'(vec2);
  endfunction
  function automatic int g_busy(input int sel);
    return sel != 0 ? int'(busy3) : int'(busy2);
  endfunction
  function automatic int g_done(input int sel);
    return sel != 0 ? int'(done3) : int'(done2);
  endfunction
  function automatic int g_pass(input int sel);
    return sel != 0 ? int'(pass3) : int'(pass2);
  endfunction
  function automatic int g_err(input int sel);
    return sel != 0 ? int'(err3) : int'(err2);
  endfunction
  function automatic int g_bad(input int sel);
    return sel != 0 ? int'(bad3) : int'(bad2);
  endfunction
  function automatic int g_fv(input int sel);
    return sel != 0 ? int'(fv3) : int'(fv2);
  endfunction

  // reference: compare the two truth tables entry by entry
  task automatic model(input logic [7:0] fa, input logic [7:0] fb,
                       input int n, output int err,
                       output int first, output int fv);
    err = 0;
    first = 0;
    fv = 0;
    for (int i = 0; i < (1 << n); i++) begin
      if (fa[i] != fb[i]) begin
        if (fv == 0) begin
          first = i;
          fv = 1;
        end
        err++;
      end
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel != 0) start3 = v;
    else start2 = v;
  endtask

  // one full sweep, checking per-cycle vec/busy and the final results
  task automatic sweep(input int sel, input logic [7:0] fa,
                       input logic [7:0] fb, input int exp_err,
                       input int exp_first, input int exp_fv,
                       input bit mid_start, input string tag);
    int n = sel != 0 ? 3 : 2;
    int s = sel != 0 ? 3 : 1;
    int len = (1 << n) * (s + 1);
    if (sel != 0) begin
      fa3 = fa;
      fb3 = fb;
    end else begin
      fa2 = fa[3:0];
      fb2 = fb[3:0];
    end
    @(negedge clk);
    set_start(sel, 1'b1);
    for (int t = 0; t < len; t++) begin
      @(negedge clk);
      set_start(sel, 1'b0);
      if (t == 0) begin
        chk({tag, "_clr_err"}, g_err(sel), 0);
        chk({tag, "_clr_fv"}, g_fv(sel), 0);
        chk({tag, "_clr_bad"}, g_bad(sel), 0);
        chk({tag, "_clr_done"}, g_done(sel), 0);
        chk({tag, "_clr_pass"}, g_pass(sel), 0);
      end
      chk({tag, "_vec"}, g_vec(sel), t / (s + 1));
      chk({tag, "_busy"}, g_busy(sel), 1);
      if (mid_start && t == 3) set_start(sel, 1'b1);
    end
    @(negedge clk);
    set_start(sel, 1'b0);
    chk({tag, "_done"}, g_done(sel), 1);
    chk({tag, "_busy_end"}, g_busy(sel), 0);
    chk({tag, "_pass"}, g_pass(sel), exp_err == 0 ? 1 : 0);
    chk({tag, "_err"}, g_err(sel), exp_err);
    chk({tag, "_fv"}, g_fv(sel), exp_fv);
    if (exp_fv != 0) chk({tag, "_first"}, g_bad(sel), exp_first);
    repeat (2) @(negedge clk);
    chk({tag, "_done_held"}, g_done(sel), 1);
  endtask

  typedef struct {
    logic [3:0] fa;
    logic [3:0] fb;
    int         err;
    int         first;
    int         fv;
    string      name;
  } vrec_t;

  vrec_t tbl[4];

  initial begin
    int e, f, v;
    logic [7:0] ra, rb;

    tbl[0] = '{4'b1110, 4'b1110, 0, 0, 0, "equiv"};
    tbl[1] = '{4'b0001, 4'b1110, 4, 0, 1, "nor_or"};
    tbl[2] = '{4'b1010, 4'b1110, 1, 2, 1, "fault2"};
    tbl[3] = '{4'b1010, 4'b1110, 1, 2, 1, "fault2_rerun"};

    #12;
    chk("rst_vec", int'(vec2), 0);
    chk("rst_busy", int'(busy2), 0);
    chk("rst_done", int'(done2), 0);
    chk("rst_err3", int'(err3), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++)
      sweep(0, {4'b0, tbl[i].fa}, {4'b0, tbl[i].fb}, tbl[i].err,
            tbl[i].first, tbl[i].fv, 1'b0, tbl[i].name);

    sweep(0, 8'h0e, 8'h0e, 0, 0, 0, 1'b1, "midstart");

    // abort three edges after acceptance, all vectors mismatching
    fa2 = 4'b0001;
    fb2 = 4'b1110;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort2 = 1'b1;
    @(negedge clk);
    abort2 = 1'b0;
    chk("abort_busy", int'(busy2), 0);
    chk("abort_done", int'(done2), 0);
    chk("abort_pass", int'(pass2), 0);
    chk("abort_err", int'(err2), 1);
    chk("abort_fv", int'(fv2), 1);
    chk("abort_vec", int'(vec2), 1);
    repeat (3) @(negedge clk);
    chk("abort_idle_busy", int'(busy2), 0);
    chk("abort_idle_vec", int'(vec2), 1);
    start2 = 1'b1;
    abort2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    abort2 = 1'b0;
    chk("start_abort_busy", int'(busy2), 0);
    chk("start_abort_err", int'(err2), 1);
    @(negedge clk);
    chk("start_abort_vec", int'(vec2), 1);

    // asynchronous reset between edges while vec=1
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_vec", int'(vec2), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vec", int'(vec2), 0);
    chk("arst_busy", int'(busy2), 0);
    chk("arst_err", int'(err2), 0);
    chk("arst_fv", int'(fv2), 0);
    chk("arst_bad", int'(bad2), 0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep(0, 8'h0e, 8'h0e, 0, 0, 0, 1'b0, "post_rst");

    sweep(1, 8'hfe, 8'hfe, 0, 0, 0, 1'b0, "n3_equiv");

    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom);
      rb = (i % 2 == 0) ? ra ^ 8'($urandom_range(0, 15)) : 8'($urandom);
      model(ra, rb, 2, e, f, v);
      sweep(0, ra, rb, e, f, v, 1'b0, "rnd2");
    end
    for (int i = 0; i < 3; i++) begin
      ra = 8'($urandom);
      rb = ra ^ (8'(1) << $urandom_range(0, 7)) ^ 8'($urandom_range(0, 3));
      model(ra, rb, 3, e, f, v);
      sweep(1, ra, rb, e, f, v, 1'b0, "rnd3");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
